// File: rtl/if_id_pipe_reg_if.sv
// IF->ID handshake bundle: fetch side (in_*), decode side (out_*), flush and occupancy.
interface if_id_pipe_reg_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_next;
  logic [1:0]      occupancy;

  // Environment side: drives fetch words, flush and the decode-side ready.
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc_next, occupancy
  );

  // Pipeline register side.
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc_next, occupancy
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with optional 2-entry skid buffer, flush and
// precomputed fall-through PC.
//
// state | meaning
// EMPTY | nothing held, outputs show NOP
// ONE   | main entry holds the word presented to ID
// TWO   | main and skid both full, in_ready low (skid build only)
module if_id_pipe_reg #(
  parameter int          XLEN      = 32,
  parameter int          ILEN      = 32,
  parameter int          PC_INC    = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter bit          SKID_EN   = 1'b1
) (
  input logic             clk,
  input logic             reset,
  if_id_pipe_reg_if.slave bus
);

  localparam logic [XLEN-1:0] PC_INC_W = XLEN'(PC_INC);
  localparam logic [ILEN-1:0] NOP_W    = ILEN'(NOP_INSTR);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            ready_q;
  logic            accept;
  logic            consume;
  logic            load_main;
  logic            load_skid;
  logic            move_skid;
  logic [XLEN-1:0] in_pc_next;

  logic [ILEN-1:0] main_instr;
  logic [XLEN-1:0] main_pc;
  logic [XLEN-1:0] main_pc_next;
  logic [ILEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_pc_next;

  assign accept     = bus.in_valid & bus.in_ready;
  assign consume    = bus.out_valid & bus.out_ready;
  assign in_pc_next = bus.in_pc + PC_INC_W;

  // Without the skid entry, a full main entry can only take a word when ID drains it the same edge.
  assign bus.in_ready    = ~reset & (SKID_EN ? ready_q : ((state == EMPTY) | bus.out_ready));
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_instr   = (state != EMPTY) ? main_instr : NOP_W;
  assign bus.out_pc      = main_pc;
  assign bus.out_pc_next = main_pc_next;
  assign bus.occupancy   = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

  // Next state and entry-load controls; flush discards everything including this edge's accept.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_nxt = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register plus registered in_ready, which looks one edge ahead at the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != TWO);
    end
  end

  // Entry storage; pc_next is computed once at capture so ID needs no adder.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_instr   <= NOP_W;
      main_pc      <= '0;
      main_pc_next <= '0;
      skid_instr   <= NOP_W;
      skid_pc      <= '0;
      skid_pc_next <= '0;
    end else begin
      if (load_main) begin
        main_instr   <= bus.in_instr;
        main_pc      <= bus.in_pc;
        main_pc_next <= in_pc_next;
      end else if (move_skid) begin
        main_instr   <= skid_instr;
        main_pc      <= skid_pc;
        main_pc_next <= skid_pc_next;
      end
      if (load_skid) begin
        skid_instr   <= bus.in_instr;
        skid_pc      <= bus.in_pc;
        skid_pc_next <= in_pc_next;
      end else if (move_skid) begin
        skid_instr   <= NOP_W;
        skid_pc      <= '0;
        skid_pc_next <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a skid build (d0) and a single-entry build (d1)
// driven with identical stimulus; a directed table for the skid build, then
// random traffic checked against a 2-deep FIFO reference model for both.
module tb_if_id_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  if_id_pipe_reg_if #(.XLEN(32), .ILEN(32)) b0 ();
  if_id_pipe_reg_if #(.XLEN(32), .ILEN(32)) b1 ();

  if_id_pipe_reg #(.XLEN(32), .ILEN(32), .PC_INC(4), .NOP_INSTR(NOP), .SKID_EN(1'b1)) dut_skid (
    .clk(clk), .reset(reset), .bus(b0));
  if_id_pipe_reg #(.XLEN(32), .ILEN(32), .PC_INC(4), .NOP_INSTR(NOP), .SKID_EN(1'b0)) dut_flat (
    .clk(clk), .reset(reset), .bus(b1));

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Reference model: an in-order FIFO of held words per build.
  ent_t m_ent [2][2];
  int   m_cnt [2];
  logic m_rdy [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input logic rst, input logic iv, input logic fl,
                            input logic ordy, input logic [31:0] ins, input logic [31:0] pc);
    logic rdy, acc, con;
    rdy = ~rst & ((d == 0) ? m_rdy[d] : (m_cnt[d] == 0 || ordy));
    acc = iv & rdy;
    con = (m_cnt[d] > 0) & ordy;
    if (rst || fl) begin
      m_cnt[d] = 0;
      m_rdy[d] = 1'b1;
    end else begin
      if (con) begin
        m_ent[d][0] = m_ent[d][1];
        m_cnt[d]--;
      end
      if (acc && m_cnt[d] < 2) begin
        m_ent[d][m_cnt[d]] = '{instr: ins, pc: pc};
        m_cnt[d]++;
      end
      m_rdy[d] = (m_cnt[d] < 2);
    end
  endtask

  task automatic model_check(input int d, input logic rst, input logic ordy);
    logic        a_v, a_r;
    logic [1:0]  a_o;
    logic [31:0] a_i, a_p, a_n;
    logic        e_r;
    if (d == 0) begin
      a_v = b0.out_valid; a_r = b0.in_ready; a_o = b0.occupancy;
      a_i = b0.out_instr; a_p = b0.out_pc;   a_n = b0.out_pc_next;
    end else begin
      a_v = b1.out_valid; a_r = b1.in_ready; a_o = b1.occupancy;
      a_i = b1.out_instr; a_p = b1.out_pc;   a_n = b1.out_pc_next;
    end
    e_r = ~rst & ((d == 0) ? m_rdy[d] : (m_cnt[d] == 0 || ordy));
    chk($sformatf("d%0d out_valid", d), 32'(a_v), 32'(m_cnt[d] > 0));
    chk($sformatf("d%0d occupancy", d), 32'(a_o), 32'(m_cnt[d]));
    chk($sformatf("d%0d in_ready", d), 32'(a_r), 32'(e_r));
    if (m_cnt[d] > 0) begin
      chk($sformatf("d%0d out_instr", d), a_i, m_ent[d][0].instr);
      chk($sformatf("d%0d out_pc", d), a_p, m_ent[d][0].pc);
      chk($sformatf("d%0d out_pc_next", d), a_n, m_ent[d][0].pc + 32'd4);
    end else begin
      chk($sformatf("d%0d out_instr nop", d), a_i, NOP);
    end
    if (rst) begin
      chk($sformatf("d%0d reset out_pc", d), a_p, 32'd0);
      chk($sformatf("d%0d reset out_pc_next", d), a_n, 32'd0);
    end
  endtask

  // One clock: drive at the falling edge, advance the model, check at the next falling edge.
  task automatic step(input logic rst, input logic iv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic fl, input logic ordy);
    reset = rst;
    b0.in_valid = iv; b0.in_pc = pc; b0.in_instr = ins; b0.flush = fl; b0.out_ready = ordy;
    b1.in_valid = iv; b1.in_pc = pc; b1.in_instr = ins; b1.flush = fl; b1.out_ready = ordy;
    model_step(0, rst, iv, fl, ordy, ins, pc);
    model_step(1, rst, iv, fl, ordy, ins, pc);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    model_check(0, rst, ordy);
    model_check(1, rst, ordy);
  endtask

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic        fl;
    logic        ordy;
    logic [31:0] pc;
    logic        ev;
    logic [1:0]  occ;
    logic        rdy;
    logic [31:0] epc;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic iv, input logic fl, input logic ordy,
                              input logic [31:0] pc, input logic ev, input logic [1:0] occ,
                              input logic rdy, input logic [31:0] epc);
    vec_t v;
    v = '{rst: rst, iv: iv, fl: fl, ordy: ordy, pc: pc, ev: ev, occ: occ, rdy: rdy, epc: epc};
    return v;
  endfunction

  vec_t tv [22];

  initial begin
    //        rst iv fl rdy  pc            ev occ rdy  exp pc
    tv[0]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    tv[1]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    tv[2]  = mk(0, 1, 0, 1, 32'h100,       1, 1, 1, 32'h100);
    tv[3]  = mk(0, 1, 0, 1, 32'h104,       1, 1, 1, 32'h104);
    tv[4]  = mk(0, 1, 0, 1, 32'h108,       1, 1, 1, 32'h108);
    tv[5]  = mk(0, 0, 0, 1, 32'h0,         0, 0, 1, 32'h0);
    tv[6]  = mk(0, 1, 0, 0, 32'h100,       1, 1, 1, 32'h100);
    tv[7]  = mk(0, 1, 0, 0, 32'h104,       1, 2, 0, 32'h100);
    tv[8]  = mk(0, 1, 0, 0, 32'h108,       1, 2, 0, 32'h100);
    tv[9]  = mk(0, 1, 0, 1, 32'h108,       1, 1, 1, 32'h104);
    tv[10] = mk(0, 1, 0, 1, 32'h108,       1, 1, 1, 32'h108);
    tv[11] = mk(0, 0, 0, 1, 32'h0,         0, 0, 1, 32'h0);
    tv[12] = mk(0, 1, 0, 0, 32'h1F0,       1, 1, 1, 32'h1F0);
    tv[13] = mk(0, 1, 0, 0, 32'h1F4,       1, 2, 0, 32'h1F0);
    tv[14] = mk(0, 1, 1, 1, 32'h200,       0, 0, 1, 32'h0);
    tv[15] = mk(0, 1, 0, 0, 32'h300,       1, 1, 1, 32'h300);
    tv[16] = mk(0, 1, 1, 0, 32'h304,       0, 0, 1, 32'h0);
    tv[17] = mk(0, 0, 0, 1, 32'h0,         0, 0, 1, 32'h0);
    tv[18] = mk(0, 1, 0, 0, 32'hFFFF_FFFC, 1, 1, 1, 32'hFFFF_FFFC);
    tv[19] = mk(0, 1, 0, 0, 32'h400,       1, 2, 0, 32'hFFFF_FFFC);
    tv[20] = mk(1, 1, 0, 0, 32'h404,       0, 0, 0, 32'h0);
    tv[21] = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 32'h0);

    reset = 1'b1;
    b0.in_valid = 1'b0; b0.in_pc = '0; b0.in_instr = '0; b0.flush = 1'b0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_pc = '0; b1.in_instr = '0; b1.flush = 1'b0; b1.out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      m_rdy[d] = 1'b1;
    end
    @(negedge clk);

    // Directed table against the skid build.
    for (int i = 0; i < 22; i++) begin
      logic [31:0] e_instr;
      logic [31:0] e_next;
      step(tv[i].rst, tv[i].iv, tv[i].pc, tv[i].pc ^ KEY, tv[i].fl, tv[i].ordy);
      e_instr = tv[i].ev ? (tv[i].epc ^ KEY) : NOP;
      e_next  = tv[i].ev ? (tv[i].epc + 32'd4) : 32'd0;
      chk($sformatf("vec%0d out_valid", i), 32'(b0.out_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d occupancy", i), 32'(b0.occupancy), 32'(tv[i].occ));
      chk($sformatf("vec%0d in_ready", i), 32'(b0.in_ready), 32'(tv[i].rdy));
      chk($sformatf("vec%0d out_instr", i), b0.out_instr, e_instr);
      if (tv[i].ev || tv[i].rst) begin
        chk($sformatf("vec%0d out_pc", i), b0.out_pc, tv[i].epc);
        chk($sformatf("vec%0d out_pc_next", i), b0.out_pc_next, e_next);
      end
    end

    // Wrap: explicit check that the fall-through PC rolls over to zero.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b0);
    chk("wrap out_pc_next d1", b1.out_pc_next, 32'h0000_0000);

    // Single-entry build: in_ready follows out_ready combinationally within the cycle.
    chk("flat full in_ready low", 32'(b1.in_ready), 32'd0);
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    #1;
    chk("flat same-cycle in_ready high", 32'(b1.in_ready), 32'd1);
    @(negedge clk);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h500, 32'h500 ^ KEY, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h504, 32'h504 ^ KEY, 1'b0, 1'b1);
    chk("flat replace out_pc", b1.out_pc, 32'h504);
    step(1'b0, 1'b1, 32'h508, 32'h508 ^ KEY, 1'b0, 1'b1);
    chk("flat replace out_pc 2", b1.out_pc, 32'h508);

    // Random traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      logic        rst, iv, fl, ordy;
      logic [31:0] pc;
      rst  = ($urandom_range(0, 59) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      pc   = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      step(rst, iv, pc, $urandom(), fl, ordy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
